// File: rtl/alu_pkg.sv
// Shared types for the serial add/subtract datapath: FSM states and op encodings.
package alu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/addsub_digit.sv
// Combinational DIGIT-bit ripple adder. Subtraction is handled upstream by inverting
// the operand when it is latched, so each cell runs with its op input tied to add.
module addsub_digit #(
  parameter int DIGIT = 8
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             cin,
  output logic [DIGIT-1:0] sum,
  output logic             cout,
  output logic             c_msb
);

  localparam logic CELL_OP = 1'b0;

  logic [DIGIT:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < DIGIT; i++) begin : g_cell
    logic yb;
    assign yb       = y[i] ^ CELL_OP;
    assign sum[i]   = x[i] ^ yb ^ c[i];
    assign c[i+1]   = (x[i] & yb) | (c[i] & (x[i] ^ yb));
  end

  assign cout  = c[DIGIT];
  assign c_msb = c[DIGIT-1];

endmodule

// File: rtl/addsub_serial_nbit.sv
// Digit-serial WIDTH-bit add/subtract: DIGIT bits per RUN cycle, out_valid NDIG+1 edges
// after accept counting the accept edge; result/flags held in DONE until out_ready.
module addsub_serial_nbit
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DIGIT = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = $clog2(NDIG + 1);
  localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;

  logic [DIGIT-1:0] dsum;
  logic             dcout;
  logic             dc_msb;
  logic [WIDTH-1:0] acc_shift;

  addsub_digit #(.DIGIT(DIGIT)) u_digit (
    .x     (a_q[DIGIT-1:0]),
    .y     (b_q[DIGIT-1:0]),
    .cin   (carry_q),
    .sum   (dsum),
    .cout  (dcout),
    .c_msb (dc_msb)
  );

  // Each new digit sum enters at the top, so after NDIG steps the low digit sits at bit 0.
  if (NDIG == 1) begin : g_acc_single
    assign acc_shift = dsum;
  end else begin : g_acc_multi
    assign acc_shift = {dsum, acc_q[WIDTH-1:DIGIT]};
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    result_d = result_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    zero_d   = zero_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b ^ {WIDTH{op == OP_SUB}};
          carry_d = (op == OP_SUB);
          cnt_d   = '0;
          acc_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_d     = a_q >> DIGIT;
        b_d     = b_q >> DIGIT;
        acc_d   = acc_shift;
        carry_d = dcout;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          result_d = acc_shift;
          cout_d   = dcout;
          ovf_d    = dc_msb ^ dcout;
          zero_d   = (acc_shift == '0);
          state_d  = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      result_q <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
      zero_q   <= zero_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign result    = result_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
  assign zero      = zero_q;

endmodule
